// File: rtl/regfile_pkg.sv
// Shared defaults and requester indices for the register-file write arbiter.
package regfile_pkg;
  localparam int DEF_WIDTH         = 16;
  localparam int DEF_REGISTER_BITS = 4;
  localparam int DEF_NUM_REQ       = 3;
  localparam int GRANT_ID_W        = 3;
  localparam int ZERO_REG          = 0;

  localparam int REQ_ALU  = 0;
  localparam int REQ_LOAD = 1;
  localparam int REQ_HOST = 2;
endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant searched from rr_ptr upward with wrap;
// the pointer moves past the winner on every grant.
module rr_arbiter
  import regfile_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  localparam int PTR_W  = $clog2(NUM_REQ)
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               hold,
  input  logic [NUM_REQ-1:0] req_valid,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   rr_ptr
);

  logic [PTR_W-1:0] rr_ptr_q;
  logic [PTR_W-1:0] rr_ptr_d;
  logic [PTR_W-1:0] win;
  logic [PTR_W-1:0] sel;
  logic             found;
  int               idx;

  always_comb begin
    grant = '0;
    win   = '0;
    sel   = '0;
    idx   = 0;
    found = 1'b0;
    // Reset is folded in here so ready never asserts while the block is held in reset.
    if (reset && !hold) begin
      for (int k = 0; k < NUM_REQ; k++) begin
        idx = int'(rr_ptr_q) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        sel = PTR_W'(idx);
        if (!found && req_valid[sel]) begin
          grant[sel] = 1'b1;
          win        = sel;
          found      = 1'b1;
        end
      end
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (found) begin
      rr_ptr_d = (win == PTR_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rr_ptr_q <= '0;
    else        rr_ptr_q <= rr_ptr_d;
  end

  assign rr_ptr = rr_ptr_q;

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the register file write port among NUM_REQ writeback sources; the
// winning request is registered for one cycle and drives the write port.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int WIDTH         = DEF_WIDTH,
  parameter int REGISTER_BITS = DEF_REGISTER_BITS,
  parameter int NUM_REQ       = DEF_NUM_REQ
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         hold,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*REGISTER_BITS-1:0] req_addr,
  input  logic [NUM_REQ*WIDTH-1:0]     req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         shouldWrite,
  output logic [REGISTER_BITS-1:0]     writeAddress,
  output logic [WIDTH-1:0]             writeData,
  output logic [(1<<REGISTER_BITS)-1:0] pending_mask,
  output logic [GRANT_ID_W-1:0]        grant_id
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int NREG  = 1 << REGISTER_BITS;

  logic [NUM_REQ-1:0]       grant;
  logic [PTR_W-1:0]         unused_rr_ptr;
  logic                     grant_any;
  logic [GRANT_ID_W-1:0]    sel_id;
  logic [REGISTER_BITS-1:0] sel_addr;
  logic [WIDTH-1:0]         sel_data;

  logic                     should_write_q, should_write_d;
  logic [REGISTER_BITS-1:0] write_addr_q,   write_addr_d;
  logic [WIDTH-1:0]         write_data_q,   write_data_d;
  logic [NREG-1:0]          pending_q,      pending_d;
  logic [GRANT_ID_W-1:0]    grant_id_q,     grant_id_d;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .clock     (clock),
    .reset     (reset),
    .hold      (hold),
    .req_valid (req_valid),
    .grant     (grant),
    .rr_ptr    (unused_rr_ptr)
  );

  assign req_ready = grant;

  always_comb begin
    grant_any = |grant;
    sel_id    = '0;
    sel_addr  = '0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        sel_id   = GRANT_ID_W'(i);
        sel_addr = req_addr[i*REGISTER_BITS +: REGISTER_BITS];
        sel_data = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // Writes to register 0 take their arbitration turn but never reach the file.
  always_comb begin
    should_write_d = grant_any && (sel_addr != REGISTER_BITS'(ZERO_REG));
    write_addr_d   = grant_any ? sel_addr : write_addr_q;
    write_data_d   = grant_any ? sel_data : write_data_q;
    grant_id_d     = grant_any ? sel_id   : grant_id_q;
    pending_d      = '0;
    if (should_write_d) pending_d[sel_addr] = 1'b1;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      should_write_q <= 1'b0;
      write_addr_q   <= '0;
      write_data_q   <= '0;
      pending_q      <= '0;
      grant_id_q     <= '0;
    end else begin
      should_write_q <= should_write_d;
      write_addr_q   <= write_addr_d;
      write_data_q   <= write_data_d;
      pending_q      <= pending_d;
      grant_id_q     <= grant_id_d;
    end
  end

  assign shouldWrite  = should_write_q;
  assign writeAddress = write_addr_q;
  assign writeData    = write_data_q;
  assign pending_mask = pending_q;
  assign grant_id     = grant_id_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Scoreboard bench for regfile_write_arbiter: stimulus queues expected writes,
// a monitor pops them whenever the write port is active.
module tb_regfile_write_arbiter;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        hold  = 1'b0;
  logic [2:0]  req_valid = '0;
  logic [11:0] req_addr  = '0;
  logic [47:0] req_data  = '0;
  logic [2:0]  req_ready;
  logic        shouldWrite;
  logic [3:0]  writeAddress;
  logic [15:0] writeData;
  logic [15:0] pending_mask;
  logic [2:0]  grant_id;

  regfile_write_arbiter #(.WIDTH(16), .REGISTER_BITS(4), .NUM_REQ(3)) dut (
    .clock        (clock),
    .reset        (reset),
    .hold         (hold),
    .req_valid    (req_valid),
    .req_addr     (req_addr),
    .req_data     (req_data),
    .req_ready    (req_ready),
    .shouldWrite  (shouldWrite),
    .writeAddress (writeAddress),
    .writeData    (writeData),
    .pending_mask (pending_mask),
    .grant_id     (grant_id)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0]  a;
    logic [15:0] d;
    logic [2:0]  id;
  } exp_t;

  exp_t        q[$];
  int          vectors = 0;
  int          miscompares = 0;
  logic [3:0]  a [3];
  logic [15:0] d [3];
  logic [15:0] rf [16];
  bit          wr_seen [16];
  bit          zero_chk = 0;
  logic [2:0]  zero_id = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic [2:0] v, input logic h, input logic [2:0] exp_rdy, input string name);
    @(negedge clock);
    if (zero_chk) begin
      chk("reg0_we",   32'(shouldWrite),  32'd0);
      chk("reg0_pend", 32'(pending_mask), 32'd0);
      chk("reg0_gid",  32'(grant_id),     32'(zero_id));
      zero_chk = 0;
    end
    req_valid = v;
    hold      = h;
    for (int i = 0; i < 3; i++) begin
      req_addr[i*4 +: 4]   = a[i];
      req_data[i*16 +: 16] = d[i];
    end
    #1;
    chk(name, 32'(req_ready), 32'(exp_rdy));
    for (int i = 0; i < 3; i++) begin
      if (exp_rdy[i]) begin
        if (a[i] != 4'd0) q.push_back('{a: a[i], d: d[i], id: 3'(i)});
        else begin
          zero_chk = 1;
          zero_id  = 3'(i);
        end
      end
    end
  endtask

  // Monitor: every active write-port cycle must match the oldest queued grant.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (reset && shouldWrite) begin
        rf[writeAddress]      = writeData;
        wr_seen[writeAddress] = 1'b1;
        if (q.size() == 0) begin
          chk("spurious_write", 32'(shouldWrite), 32'd0);
        end else begin
          e = q.pop_front();
          chk("wr_addr", 32'(writeAddress), 32'(e.a));
          chk("wr_data", 32'(writeData),    32'(e.d));
          chk("wr_gid",  32'(grant_id),     32'(e.id));
          chk("wr_pend", 32'(pending_mask), 32'd1 << e.a);
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) begin
      rf[i] = '0;
      wr_seen[i] = 1'b0;
    end
    for (int i = 0; i < 3; i++) begin
      a[i] = '0;
      d[i] = '0;
    end

    // Reset with every requester active.
    req_valid = 3'b111;
    #1 reset = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    chk("rst_ready", 32'(req_ready),    32'd0);
    chk("rst_we",    32'(shouldWrite),  32'd0);
    chk("rst_pend",  32'(pending_mask), 32'd0);
    chk("rst_addr",  32'(writeAddress), 32'd0);
    chk("rst_data",  32'(writeData),    32'd0);
    chk("rst_gid",   32'(grant_id),     32'd0);
    req_valid = 3'b000;
    @(negedge clock);
    reset = 1'b1;

    // First transfer after reset.
    a[0] = 4'd3; d[0] = 16'h1234;
    step(3'b001, 1'b0, 3'b001, "rdy_first");
    step(3'b000, 1'b0, 3'b000, "rdy_idle");

    // Return the pointer to 0, then all three contend.
    a[2] = 4'd7; d[2] = 16'h7777;
    step(3'b100, 1'b0, 3'b100, "rdy_req2");
    a[0] = 4'd1; d[0] = 16'h0101;
    a[1] = 4'd2; d[1] = 16'h0202;
    a[2] = 4'd4; d[2] = 16'h0404;
    step(3'b111, 1'b0, 3'b001, "rr_0");
    step(3'b111, 1'b0, 3'b010, "rr_1");
    step(3'b111, 1'b0, 3'b100, "rr_2");
    step(3'b111, 1'b0, 3'b001, "rr_3");
    step(3'b111, 1'b0, 3'b010, "rr_4");
    step(3'b111, 1'b0, 3'b100, "rr_5");
    step(3'b000, 1'b0, 3'b000, "rdy_drain");

    // Register 0 consumes req1's turn; pointer moves to 2.
    a[1] = 4'd0; d[1] = 16'hFFFF;
    step(3'b010, 1'b0, 3'b010, "rdy_reg0");

    // Collision on register 5 starting from pointer 2.
    a[0] = 4'd5; d[0] = 16'hAAAA;
    a[2] = 4'd5; d[2] = 16'h5555;
    step(3'b101, 1'b0, 3'b100, "col_first");
    step(3'b001, 1'b0, 3'b001, "col_second");
    step(3'b000, 1'b0, 3'b000, "col_idle");

    // Hold right after a grant: the grant still commits, no new grants.
    a[1] = 4'd9; d[1] = 16'hBEEF;
    step(3'b010, 1'b0, 3'b010, "hold_pre");
    a[0] = 4'd10; d[0] = 16'h0A0A;
    a[2] = 4'd12; d[2] = 16'h0C0C;
    step(3'b111, 1'b1, 3'b000, "hold_1");
    step(3'b111, 1'b1, 3'b000, "hold_2");
    step(3'b111, 1'b0, 3'b100, "hold_resume");
    step(3'b001, 1'b0, 3'b001, "hold_next");
    step(3'b000, 1'b0, 3'b000, "hold_idle");

    // Asynchronous reset while a write sits in the output stage.
    a[0] = 4'd6; d[0] = 16'h5A5A;
    step(3'b001, 1'b0, 3'b001, "rdy_pre_rst");
    @(posedge clock);
    #1;
    chk("midrst_we_before", 32'(shouldWrite), 32'd1);
    #1 reset = 1'b0;
    #1;
    chk("midrst_we",    32'(shouldWrite),  32'd0);
    chk("midrst_pend",  32'(pending_mask), 32'd0);
    chk("midrst_ready", 32'(req_ready),    32'd0);
    if (q.size() > 0) void'(q.pop_back());
    req_valid = 3'b000;
    repeat (2) @(negedge clock);
    chk("midrst_addr",   32'(writeAddress), 32'd0);
    chk("midrst_nowr6",  32'(wr_seen[6]),   32'd0);
    reset = 1'b1;
    repeat (3) @(negedge clock);

    chk("queue_empty", 32'(q.size()), 32'd0);
    chk("rf5_final",   32'(rf[5]),    32'hAAAA);
    chk("rf9_final",   32'(rf[9]),    32'hBEEF);
    chk("rf0_unwritten", 32'(wr_seen[0]), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
